vproc_opfetch_seq: RTL and testbench

//  Operand-fetch sequencer between decode/queue and the ALU/MUL units. Accepts one

---
 rtl/vproc_opfetch_seq.sv | 186 ++++++++++++++++++
 tb/tb_vproc_opfetch_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_opfetch_seq.sv
// Operand-fetch sequencer: walks the EMUL register group of one instruction, issuing one
// register-file read per source operand per beat and presenting the read data downstream.
module vproc_opfetch_seq #(
  parameter int unsigned VREG_W = 128
) (
  input  logic              clk_i,
  input  logic              async_rst_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [1:0]        op_emul_i,
  input  logic              op_vs1_vreg_i,
  input  logic [4:0]        op_vs1_addr_i,
  input  logic              op_vs1_narrow_i,
  input  logic              op_vs2_vreg_i,
  input  logic [4:0]        op_vs2_addr_i,
  input  logic              op_vs2_narrow_i,
  input  logic [31:0]       pend_wr_i,
  output logic [4:0]        rd_addr1_o,
  output logic [4:0]        rd_addr2_o,
  input  logic [VREG_W-1:0] rd_data1_i,
  input  logic [VREG_W-1:0] rd_data2_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [VREG_W-1:0] out_op1_o,
  output logic [VREG_W-1:0] out_op2_o,
  output logic              out_first_o,
  output logic              out_last_o,
  output logic [31:0]       clr_rd_hazard_o
);

  localparam int unsigned HALF_W = VREG_W / 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e     state;
  logic [2:0] cnt;

  // latched instruction fields
  logic [1:0] emul_q;
  logic       vs1_vreg_q;
  logic [4:0] vs1_base_q;
  logic       vs1_narrow_q;
  logic       vs2_vreg_q;
  logic [4:0] vs2_base_q;
  logic       vs2_narrow_q;

  // per-beat copies so a stalled beat survives acceptance of the next instruction
  logic       beat1_vreg;
  logic       beat1_narrow;
  logic       beat1_shift;
  logic       beat2_vreg;
  logic       beat2_narrow;
  logic       beat2_shift;

  logic [2:0]  last_cnt;
  logic [4:0]  addr1;
  logic [4:0]  addr2;
  logic        fetch1;
  logic        fetch2;
  logic        shift1;
  logic        shift2;
  logic        done1;
  logic        done2;
  logic        haz;
  logic        issue;
  logic [31:0] clr_next;

  assign op_ready_o = (state == IDLE);

  // Address generation, hazard check and issue decision for the current beat
  always_comb begin
    last_cnt = 3'((4'd1 << emul_q) - 4'd1);
    addr1    = vs1_narrow_q ? (vs1_base_q | 5'(cnt[2:1])) : (vs1_base_q | 5'(cnt));
    addr2    = vs2_narrow_q ? (vs2_base_q | 5'(cnt[2:1])) : (vs2_base_q | 5'(cnt));
    shift1   = vs1_narrow_q & cnt[0];
    shift2   = vs2_narrow_q & cnt[0];
    fetch1   = vs1_vreg_q & ~shift1;
    fetch2   = vs2_vreg_q & ~shift2;
    // a narrow register is finished only after its upper half has been read
    done1    = vs1_vreg_q & (~vs1_narrow_q | cnt[0]);
    done2    = vs2_vreg_q & (~vs2_narrow_q | cnt[0]);
    haz      = (fetch1 & pend_wr_i[addr1]) | (fetch2 & pend_wr_i[addr2]);
    issue    = (state == FETCH) & ~haz & (~out_valid_o | out_ready_i);
    clr_next = '0;
    if (done1) clr_next[addr1] = 1'b1;
    if (done2) clr_next[addr2] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      emul_q          <= '0;
      vs1_vreg_q      <= 1'b0;
      vs1_base_q      <= '0;
      vs1_narrow_q    <= 1'b0;
      vs2_vreg_q      <= 1'b0;
      vs2_base_q      <= '0;
      vs2_narrow_q    <= 1'b0;
      beat1_vreg      <= 1'b0;
      beat1_narrow    <= 1'b0;
      beat1_shift     <= 1'b0;
      beat2_vreg      <= 1'b0;
      beat2_narrow    <= 1'b0;
      beat2_shift     <= 1'b0;
      rd_addr1_o      <= '0;
      rd_addr2_o      <= '0;
      out_valid_o     <= 1'b0;
      out_first_o     <= 1'b0;
      out_last_o      <= 1'b0;
      clr_rd_hazard_o <= '0;
    end else begin
      clr_rd_hazard_o <= issue ? clr_next : 32'd0;

      if (issue) begin
        rd_addr1_o   <= addr1;
        rd_addr2_o   <= addr2;
        out_valid_o  <= 1'b1;
        out_first_o  <= (cnt == 3'd0);
        out_last_o   <= (cnt == last_cnt);
        beat1_vreg   <= vs1_vreg_q;
        beat1_narrow <= vs1_narrow_q;
        beat1_shift  <= shift1;
        beat2_vreg   <= vs2_vreg_q;
        beat2_narrow <= vs2_narrow_q;
        beat2_shift  <= shift2;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (op_valid_i) begin
            emul_q       <= op_emul_i;
            vs1_vreg_q   <= op_vs1_vreg_i;
            vs1_base_q   <= op_vs1_addr_i;
            vs1_narrow_q <= op_vs1_narrow_i;
            vs2_vreg_q   <= op_vs2_vreg_i;
            vs2_base_q   <= op_vs2_addr_i;
            vs2_narrow_q <= op_vs2_narrow_i;
            cnt          <= '0;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            if (cnt == last_cnt) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand data is steered straight from the register file using the beat's flags
  always_comb begin
    out_op1_o = '0;
    if (beat1_vreg) begin
      if (beat1_narrow) begin
        out_op1_o[HALF_W-1:0] = beat1_shift ? rd_data1_i[VREG_W-1:HALF_W] : rd_data1_i[HALF_W-1:0];
      end else begin
        out_op1_o = rd_data1_i;
      end
    end
  end

  always_comb begin
    out_op2_o = '0;
    if (beat2_vreg) begin
      if (beat2_narrow) begin
        out_op2_o[HALF_W-1:0] = beat2_shift ? rd_data2_i[VREG_W-1:HALF_W] : rd_data2_i[HALF_W-1:0];
      end else begin
        out_op2_o = rd_data2_i;
      end
    end
  end

endmodule

// File: tb/tb_vproc_opfetch_seq.sv
// Scoreboard bench for vproc_opfetch_seq: expected beats and hazard-clear pulses are queued
// when an instruction is sent and checked as the sequencer produces them.
module tb_vproc_opfetch_seq;

  localparam int unsigned VREG_W = 128;
  localparam int unsigned HALF_W = VREG_W / 2;

  typedef struct {
    logic [VREG_W-1:0] op1;
    logic [VREG_W-1:0] op2;
    logic              first;
    logic              last;
    logic              v1;
    logic              v2;
    logic [4:0]        a1;
    logic [4:0]        a2;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [1:0]        op_emul = '0;
  logic              vs1_vreg = 1'b0;
  logic [4:0]        vs1_addr = '0;
  logic              vs1_narrow = 1'b0;
  logic              vs2_vreg = 1'b0;
  logic [4:0]        vs2_addr = '0;
  logic              vs2_narrow = 1'b0;
  logic [31:0]       pend_wr = '0;
  logic [4:0]        rd_addr1;
  logic [4:0]        rd_addr2;
  logic [VREG_W-1:0] rd_data1;
  logic [VREG_W-1:0] rd_data2;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [VREG_W-1:0] out_op1;
  logic [VREG_W-1:0] out_op2;
  logic              out_first;
  logic              out_last;
  logic [31:0]       clr_rd_hazard;

  logic [VREG_W-1:0] rf [32];
  beat_t             exp_q [$];
  logic [31:0]       clr_q [$];
  beat_t             mon_e;
  int                n_cmp = 0;
  int                n_err = 0;
  int                beats_taken = 0;
  bit                rand_done;

  assign rd_data1 = rf[rd_addr1];
  assign rd_data2 = rf[rd_addr2];

  always #5 clk = ~clk;

  vproc_opfetch_seq #(.VREG_W(VREG_W)) dut (
    .clk_i           (clk),
    .async_rst_i     (rst),
    .op_valid_i      (op_valid),
    .op_ready_o      (op_ready),
    .op_emul_i       (op_emul),
    .op_vs1_vreg_i   (vs1_vreg),
    .op_vs1_addr_i   (vs1_addr),
    .op_vs1_narrow_i (vs1_narrow),
    .op_vs2_vreg_i   (vs2_vreg),
    .op_vs2_addr_i   (vs2_addr),
    .op_vs2_narrow_i (vs2_narrow),
    .pend_wr_i       (pend_wr),
    .rd_addr1_o      (rd_addr1),
    .rd_addr2_o      (rd_addr2),
    .rd_data1_i      (rd_data1),
    .rd_data2_i      (rd_data2),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_op1_o       (out_op1),
    .out_op2_o       (out_op2),
    .out_first_o     (out_first),
    .out_last_o      (out_last),
    .clr_rd_hazard_o (clr_rd_hazard)
  );

  task automatic check(input string tag, input logic [VREG_W-1:0] got, input logic [VREG_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [VREG_W-1:0] operand(input logic v, input logic [4:0] a, input logic n, input int c);
    logic [VREG_W-1:0] w;
    if (!v) return '0;
    if (n) begin
      w = rf[a | 5'(c / 2)];
      return (c % 2 == 1) ? {{HALF_W{1'b0}}, w[VREG_W-1:HALF_W]} : {{HALF_W{1'b0}}, w[HALF_W-1:0]};
    end
    return rf[a | 5'(c)];
  endfunction

  task automatic push_op(input logic [1:0] emul, input logic v1, input logic [4:0] a1, input logic n1,
                         input logic v2, input logic [4:0] a2, input logic n2);
    int b;
    beat_t e;
    logic [31:0] m;
    b = 1 << emul;
    for (int c = 0; c < b; c++) begin
      m       = '0;
      e.op1   = operand(v1, a1, n1, c);
      e.op2   = operand(v2, a2, n2, c);
      e.a1    = n1 ? (a1 | 5'(c / 2)) : (a1 | 5'(c));
      e.a2    = n2 ? (a2 | 5'(c / 2)) : (a2 | 5'(c));
      e.v1    = v1;
      e.v2    = v2;
      e.first = (c == 0);
      e.last  = (c == b - 1);
      if (v1 && (!n1 || c % 2 == 1)) m[e.a1] = 1'b1;
      if (v2 && (!n2 || c % 2 == 1)) m[e.a2] = 1'b1;
      exp_q.push_back(e);
      if (m != 0) clr_q.push_back(m);
    end
  endtask

  task automatic set_fields(input logic [1:0] emul, input logic v1, input logic [4:0] a1, input logic n1,
                            input logic v2, input logic [4:0] a2, input logic n2);
    op_emul = emul; vs1_vreg = v1; vs1_addr = a1; vs1_narrow = n1;
    vs2_vreg = v2; vs2_addr = a2; vs2_narrow = n2;
  endtask

  // returns one time unit after the accepting clock edge
  task automatic send_op(input logic [1:0] emul, input logic v1, input logic [4:0] a1, input logic n1,
                         input logic v2, input logic [4:0] a2, input logic n2);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    set_fields(emul, v1, a1, n1, v2, a2, n2);
    push_op(emul, v1, a1, n1, v2, a2, n2);
    op_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (op_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", op_ready, 1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && op_ready && !out_valid) break;
    end
    check({tag, "_beats_left"}, exp_q.size(), 0);
    check({tag, "_clr_left"}, clr_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (clr_rd_hazard != 0) begin
        if (clr_q.size() == 0) check("clr_extra", clr_rd_hazard, 0);
        else check("clr", clr_rd_hazard, clr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_extra", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("op1", out_op1, mon_e.op1);
          check("op2", out_op2, mon_e.op2);
          check("first", out_first, mon_e.first);
          check("last", out_last, mon_e.last);
          if (mon_e.v1) check("rd_addr1", rd_addr1, mon_e.a1);
          if (mon_e.v2) check("rd_addr2", rd_addr2, mon_e.a2);
        end
        beats_taken++;
      end
    end
  end

  initial begin
    int start;
    bit hit;
    logic [1:0] re;
    logic [4:0] ra1, ra2;
    for (int i = 0; i < 32; i++)
      rf[i] = {32'hA5A5_0000 | 32'(i), 32'h1111_1111 * 32'(i), 32'hC3C3_0000 | 32'(i), 32'h0F0F_0F0F ^ 32'(i)};

    // reset state
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_first", out_first, 0);
    check("rst_last", out_last, 0);
    check("rst_addr1", rd_addr1, 0);
    check("rst_addr2", rd_addr2, 0);
    check("rst_clr", clr_rd_hazard, 0);
    check("rst_ready", op_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // EMUL_4 plain fetch, consecutive addresses
    send_op(2'd2, 1'b1, 5'd8, 1'b0, 1'b1, 5'd16, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("seq_valid", out_valid, 1);
      check("seq_addr1", rd_addr1, 5'(8 + k));
    end
    drain("emul4");

    // narrow vs2 over a 4-beat group: register read twice, cleared after the upper half
    send_op(2'd2, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("narrow_addr2", rd_addr2, 5'(4 + k / 2));
    end
    drain("narrow");

    // output stall on beat2 of an EMUL_8 op
    start = beats_taken;
    send_op(2'd3, 1'b1, 5'd24, 1'b0, 1'b1, 5'd8, 1'b0);
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (beats_taken == start + 2) begin hit = 1; break; end
    end
    if (!hit) check("stall_reach", beats_taken - start, 2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_addr1", rd_addr1, 5'd26);
      check("stall_op1", out_op1, rf[26]);
      check("stall_first", out_first, 0);
      check("stall_last", out_last, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("stall");
    check("stall_count", beats_taken - start, 8);

    // pending write on v9 blocks the second beat
    pend_wr = 32'h0000_0200;
    send_op(2'd1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("haz_valid", out_valid, 0);
      check("haz_addr1", rd_addr1, 5'd8);
    end
    @(posedge clk); #1;
    pend_wr = '0;
    drain("hazard");

    // back-to-back EMUL_1 ops
    @(posedge clk); #1;
    set_fields(2'd0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd7, 1'b0);
    for (int k = 0; k < 4; k++) push_op(2'd0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd7, 1'b0);
    op_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b2b_ready", op_ready, (k % 2 == 0));
      if (k == 6) begin
        @(posedge clk); #1;
        op_valid = 1'b0;
      end
    end
    drain("b2b");

    // asynchronous reset in the middle of an EMUL_8 op
    start = beats_taken;
    send_op(2'd3, 1'b1, 5'd16, 1'b0, 1'b1, 5'd0, 1'b0);
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (beats_taken == start + 1) begin hit = 1; break; end
    end
    if (!hit) check("rst_reach", beats_taken - start, 1);
    rst = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_first", out_first, 0);
    check("mrst_addr1", rd_addr1, 0);
    check("mrst_addr2", rd_addr2, 0);
    check("mrst_clr", clr_rd_hazard, 0);
    check("mrst_op1", out_op1, 0);
    check("mrst_ready", op_ready, 1);
    exp_q.delete();
    clr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send_op(2'd1, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    drain("post_rst");

    // random ops under random backpressure
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          re  = 2'($urandom_range(0, 3));
          ra1 = 5'($urandom_range(0, 31)) & ~5'((1 << re) - 1);
          ra2 = 5'($urandom_range(0, 31)) & ~5'((1 << re) - 1);
          send_op(re, 1'($urandom_range(0, 1)), ra1, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ra2, 1'($urandom_range(0, 1)));
        end
        drain("rand");
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
